// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a framed image over UART, writes it to RAM as 32-bit words, then releases the CPU.
// Ports: clk, rst_n (async active-low); uart_rx serial input (8N1, LSB first);
//        mem_addr/mem_wdata/mem_wenable RAM write port; cpu_rst_n CPU reset (low until load done);
//        loading busy flag; load_error high in the error state.
// Define BOOT_CHECKSUM_EN to require a trailing 8-bit sum of the payload bytes.
module uart_boot_loader #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD = 115200,
  parameter int ADDR_WIDTH = 14
) (
  input  logic clk,
  input  logic rst_n,
  input  logic uart_rx,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0] mem_wenable,
  output logic cpu_rst_n,
  output logic loading,
  output logic load_error
);
  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW = $clog2(CPB + 1);
  localparam logic [CW-1:0] BIT_END = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2);
  localparam int unsigned CAP = 32'd1 << (ADDR_WIDTH - 2);
  localparam logic [7:0] MAGIC = 8'hA5;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} r_state_e;
  typedef enum logic [2:0] {
    L_MAGIC, L_LEN0, L_LEN1, L_DATA,
`ifdef BOOT_CHECKSUM_EN
    L_CSUM,
`endif
    DONE, ERROR
  } l_state_e;
`ifdef BOOT_CHECKSUM_EN
  localparam l_state_e PAYLOAD_END = L_CSUM;
`else
  localparam l_state_e PAYLOAD_END = DONE;
`endif

  r_state_e r_state_q, r_state_d;
  logic rx_s1_q, rx_s2_q, rx_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic byte_valid_q, byte_valid_d, frame_err_q, frame_err_d;

  l_state_e l_state_q, l_state_d;
  logic [15:0] len_q, len_d, word_cnt_q, word_cnt_d, n;
  logic [1:0] byte_cnt_q, byte_cnt_d;
  // only the first three bytes of a word are held; the fourth goes straight to mem_wdata
  logic [23:0] word_q, word_d;
  logic we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_prev_q <= 1'b1;
      r_state_q <= R_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      rx_byte_q <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      l_state_q <= L_MAGIC;
      len_q <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      word_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      rx_s1_q <= uart_rx;
      rx_s2_q <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      r_state_q <= r_state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      rx_byte_q <= rx_byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q <= frame_err_d;
      l_state_q <= l_state_d;
      len_q <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      word_q <= word_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
`ifdef BOOT_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end

  always_comb begin
    r_state_d = r_state_q;
    cnt_d = cnt_q + CW'(1);
    bit_d = bit_q;
    rx_byte_d = rx_byte_q;
    byte_valid_d = 1'b0;
    frame_err_d = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) r_state_d = R_START;
      end
      R_START: if (cnt_q == HALF) begin
        cnt_d = '0;
        bit_d = '0;
        r_state_d = rx_s2_q ? R_IDLE : R_DATA;
      end
      R_DATA: if (cnt_q == BIT_END) begin
        cnt_d = '0;
        rx_byte_d = {rx_s2_q, rx_byte_q[7:1]};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) r_state_d = R_STOP;
      end
      default: if (cnt_q == BIT_END) begin
        r_state_d = R_IDLE;
        byte_valid_d = rx_s2_q;
        frame_err_d = !rx_s2_q;
      end
    endcase
  end

  always_comb begin
    l_state_d = l_state_q;
    len_d = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    word_d = word_q;
    we_d = 1'b0;
    addr_d = addr_q;
    wdata_d = wdata_q;
    n = {rx_byte_q, len_q[7:0]};
`ifdef BOOT_CHECKSUM_EN
    csum_d = csum_q;
`endif
    if (frame_err_q && l_state_q != DONE) l_state_d = ERROR;
    else if (byte_valid_q)
      case (l_state_q)
        L_MAGIC, ERROR: if (rx_byte_q == MAGIC) begin
          l_state_d = L_LEN0;
          word_cnt_d = '0;
          byte_cnt_d = '0;
`ifdef BOOT_CHECKSUM_EN
          csum_d = '0;
`endif
        end
        L_LEN0: begin
          len_d = {8'd0, rx_byte_q};
          l_state_d = L_LEN1;
        end
        L_LEN1: begin
          len_d = n;
          l_state_d = 32'(n) > CAP ? ERROR : n == 16'd0 ? PAYLOAD_END : L_DATA;
        end
        L_DATA: begin
          word_d = {rx_byte_q, word_q[23:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
          csum_d = csum_q + rx_byte_q;
`endif
          if (byte_cnt_q == 2'd3) begin
            we_d = 1'b1;
            addr_d = ADDR_WIDTH'({word_cnt_q, 2'b00});
            wdata_d = {rx_byte_q, word_q};
            word_cnt_d = word_cnt_q + 16'd1;
            if (word_cnt_d == len_q) l_state_d = PAYLOAD_END;
          end
        end
`ifdef BOOT_CHECKSUM_EN
        L_CSUM: l_state_d = rx_byte_q == csum_q ? DONE : ERROR;
`endif
        default: ;
      endcase
  end

  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wenable = {4{we_q}};
  assign cpu_rst_n = l_state_q == DONE;
  assign load_error = l_state_q == ERROR;
  assign loading = !(l_state_q inside {L_MAGIC, DONE, ERROR});
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: randomized UART image streams checked against a stream-parsing reference model.
`timescale 1ns/1ps
module tb_uart_boot_loader;
  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD = 100_000;
  localparam int AW = 14;
  localparam int CPB = CLK_HZ / BAUD;
  localparam int CAP = 1 << (AW - 2);
`ifdef BOOT_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_rx = 1'b1;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0] mem_wenable;
  logic cpu_rst_n, loading, load_error;

  uart_boot_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .uart_rx(uart_rx),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wenable(mem_wenable),
    .cpu_rst_n(cpu_rst_n),
    .loading(loading),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int wr_addr[$], exp_addr[$];
  logic [31:0] wr_data[$], exp_data[$];
  logic exp_done, exp_err, exp_loading, rst_at_stop, we_prev = 1'b0;
  int done_idx;
  logic [7:0] s[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_wenable != 4'h0) begin
      check("we_all", 64'(mem_wenable), 64'hF);
      check("we_pulse", 64'(we_prev), 64'h0);
      wr_addr.push_back(int'(mem_addr));
      wr_data.push_back(mem_wdata);
    end
    we_prev = mem_wenable != 4'h0;
  end

  // Reference: scan the byte stream for magic, read length, take whole words, then the checksum.
  task automatic model(input logic [7:0] st[$]);
    int i, nn, wc;
    logic [7:0] sum;
    i = 0;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 0;
    exp_err = 0;
    exp_loading = 0;
    done_idx = -1;
    while (i < st.size() && !exp_done) begin
      if (st[i] != 8'hA5) begin
        i++;
        continue;
      end
      i++;
      exp_err = 0;
      exp_loading = 1;
      if (i + 2 > st.size()) break;
      nn = int'({st[i+1], st[i]});
      i += 2;
      if (nn > CAP) begin
        exp_err = 1;
        exp_loading = 0;
        continue;
      end
      sum = 8'd0;
      wc = 0;
      while (wc < nn && i + 4 <= st.size()) begin
        exp_addr.push_back(4 * wc);
        exp_data.push_back({st[i+3], st[i+2], st[i+1], st[i]});
        sum = sum + st[i] + st[i+1] + st[i+2] + st[i+3];
        i += 4;
        wc++;
      end
      if (wc < nn) break;
      if (CS) begin
        if (i >= st.size()) break;
        exp_loading = 0;
        if (st[i] == sum) begin
          exp_done = 1;
          done_idx = i;
        end else exp_err = 1;
        i++;
      end else begin
        exp_loading = 0;
        exp_done = 1;
        done_idx = i - 1;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rst_at_stop = cpu_rst_n;
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"}, 64'(mem_addr), 64'h0);
    check({tag, "_wdata"}, 64'(mem_wdata), 64'h0);
    check({tag, "_we"}, 64'(mem_wenable), 64'h0);
    check({tag, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'h0);
    check({tag, "_loading"}, 64'(loading), 64'h0);
    check({tag, "_err"}, 64'(load_error), 64'h0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check_reset_vals("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic finish_run(input string name, input logic [7:0] st[$]);
    repeat (4) @(negedge clk);
    check({name, "_nwr"}, 64'(wr_addr.size()), 64'(exp_addr.size()));
    for (int j = 0; j < exp_addr.size() && j < wr_addr.size(); j++) begin
      check({name, "_addr"}, 64'(wr_addr[j]), 64'(exp_addr[j]));
      check({name, "_data"}, 64'(wr_data[j]), 64'(exp_data[j]));
    end
    if (exp_addr.size() > 0) begin
      check({name, "_hold_addr"}, 64'(mem_addr), 64'(exp_addr[exp_addr.size()-1]));
      check({name, "_hold_data"}, 64'(mem_wdata), 64'(exp_data[exp_data.size()-1]));
    end
    check({name, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'(exp_done));
    check({name, "_loading"}, 64'(loading), 64'(exp_loading));
    check({name, "_err"}, 64'(load_error), 64'(exp_err));
    if (done_idx == st.size() - 1) check({name, "_rel_late"}, 64'(rst_at_stop), 64'h0);
  endtask

  task automatic run(input string name, input logic [7:0] st[$]);
    wr_addr.delete();
    wr_data.delete();
    model(st);
    foreach (st[j]) send_byte(st[j]);
    finish_run(name, st);
  endtask

  function automatic logic [7:0] psum(input logic [7:0] st[$], input int from);
    logic [7:0] r = 8'd0;
    for (int j = from; j < st.size(); j++) r = r + st[j];
    return r;
  endfunction

  initial begin
    #1;
    check_reset_vals("por");
    reset_dut();

    s = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    if (CS) s.push_back(psum(s, 3));
    run("normal", s);

    reset_dut();
    s = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    s.push_back(psum(s, 3) + 8'd1);
    s = {s, 8'hA5, 8'h00, 8'h00, 8'h00};
    run("badsum", s);

    reset_dut();
    run("oversize", '{8'hA5, 8'h01, 8'h10});
    run("maxlen", '{8'hA5, 8'h00, 8'h10});

    reset_dut();
    s = '{8'hA5, 8'h00, 8'h00};
    if (CS) s.push_back(8'h00);
    wr_addr.delete();
    wr_data.delete();
    model(s);
    send_byte(s[0]);
    uart_rx = 1'b0;
    repeat (CPB / 2 - 3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    for (int j = 1; j < s.size(); j++) send_byte(s[j]);
    finish_run("glitch", s);

    reset_dut();
    send_byte(8'h3C, 1'b0);
    repeat (CPB) @(negedge clk);
    check("frame_err", 64'(load_error), 64'h1);
    s = '{8'hA5, 8'h00, 8'h00};
    if (CS) s.push_back(8'h00);
    run("frame_recover", s);

    reset_dut();
    s = '{8'hA5, 8'h02, 8'h00};
    for (int j = 0; j < 5; j++) s.push_back(8'($urandom));
    foreach (s[j]) send_byte(s[j]);
    check("midload_loading", 64'(loading), 64'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midload");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    s = '{8'hA5, 8'h02, 8'h00};
    for (int j = 0; j < 8; j++) s.push_back(8'($urandom));
    if (CS) s.push_back(psum(s, 3));
    run("fresh", s);

    for (int t = 0; t < 6; t++) begin
      int nn;
      reset_dut();
      s.delete();
      for (int j = $urandom_range(2); j > 0; j--) s.push_back(8'($urandom_range(8'hA4)));
      s.push_back(8'hA5);
      nn = $urandom_range(1, 3);
      s.push_back(8'(nn));
      s.push_back(8'h00);
      for (int j = 0; j < 4 * nn; j++) s.push_back(8'($urandom));
      if ($urandom_range(3) != 0) s.push_back(psum(s, s.size() - 4 * nn));
      else begin
        s.push_back(psum(s, s.size() - 4 * nn) ^ 8'h01);
        s = {s, 8'hA5, 8'h01, 8'h00, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        s.push_back(psum(s, s.size() - 4));
      end
      run("rand", s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
